udp_loopback_buffered: RTL and testbench

Store-and-forward UDP echo endpoint that sits on one output of `udp_switch`, taking the place of the unbuffered `udp_loopback`. It accepts a datagram addressed to its port and buffers the whole payload in an internal RAM of parametrised depth. Only after the frame has ended cleanly does it emit a reply, with addresses and ports swapped. Oversize or errored frames are drained and dropped. A runtime mode selects plain echo, inverted echo or disabled, and frame counters are exported for debug.

---
 rtl/udp_loopback_buffered.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_udp_loopback_buffered.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_loopback_buffered.sv
// Store-and-forward UDP echo: buffers one datagram, then replies with addresses/ports swapped.
// Reply header one cycle after rx tlast; first payload beat <=2 cycles after header handshake; tx stalls hold valid/data.
module udp_loopback_buffered #(
  parameter int UDP_PORT = 1234,
  parameter int DEPTH    = 2048,
  parameter int TTL      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] local_ip,
  input  logic [1:0]  cfg_mode,
  input  logic        rx_hdr_valid_i,
  output logic        rx_hdr_ready_o,
  input  logic [31:0] rx_hdr_source_ip_i,
  input  logic [15:0] rx_hdr_source_port_i,
  input  logic [15:0] rx_hdr_dest_port_i,
  input  logic [15:0] rx_hdr_length_i,
  input  logic [7:0]  rx_tdata_i,
  input  logic        rx_tvalid_i,
  output logic        rx_tready_o,
  input  logic        rx_tlast_i,
  input  logic        rx_tuser_i,
  output logic        tx_hdr_valid_o,
  input  logic        tx_hdr_ready_i,
  output logic [5:0]  tx_ip_dscp_o,
  output logic [1:0]  tx_ip_ecn_o,
  output logic [7:0]  tx_ip_ttl_o,
  output logic [31:0] tx_ip_source_ip_o,
  output logic [31:0] tx_ip_dest_ip_o,
  output logic [15:0] tx_source_port_o,
  output logic [15:0] tx_dest_port_o,
  output logic [15:0] tx_length_o,
  output logic [15:0] tx_checksum_o,
  output logic [7:0]  tx_tdata_o,
  output logic        tx_tvalid_o,
  input  logic        tx_tready_i,
  output logic        tx_tlast_o,
  output logic        tx_tuser_o,
  output logic [15:0] stat_rx_frames,
  output logic [15:0] stat_tx_frames,
  output logic [15:0] stat_drop_frames,
  output logic        busy
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);
  localparam logic [15:0] PORT16  = 16'(UDP_PORT);
  localparam logic [7:0]  TTL8    = 8'(TTL);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RX      = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_TX_HDR  = 3'd3;
  localparam logic [2:0] S_TX_DATA = 3'd4;

  logic [7:0] mem [DEPTH];

  logic [2:0]  state_q, state_d;
  logic        hdr_rdy_q;
  logic [31:0] src_ip_q, src_ip_d;
  logic [15:0] src_port_q, src_port_d;
  logic        inv_q, inv_d;
  logic        cnt_drain_q, cnt_drain_d;
  logic [15:0] wr_ptr_q, wr_ptr_d;
  logic        ovf_q, ovf_d;
  logic [15:0] len_q, len_d;
  logic [15:0] rd_ptr_q, rd_ptr_d;
  logic        hdr_vld_q, hdr_vld_d;
  logic [15:0] stat_rx_q, stat_rx_d;
  logic [15:0] stat_tx_q, stat_tx_d;
  logic [15:0] stat_drop_q, stat_drop_d;

  logic        rd_vld_q, rd_last_q;
  logic [7:0]  rd_dat_q;
  logic        tx_vld_q, tx_last_q;
  logic [7:0]  tx_dat_q;

  logic [7:0]  hdr_ttl_q;
  logic [31:0] hdr_src_ip_q, hdr_dst_ip_q;
  logic [15:0] hdr_src_port_q, hdr_dst_port_q, hdr_len_q;

  logic rx_hdr_hs, rx_beat, tx_hdr_hs, tx_beat;
  logic wr_full, wr_en, frame_ok, hdr_load;
  logic out_adv, rd_issue;
  logic unused_hdr_len;

  // The datagram length is taken from what actually arrives, not from the header.
  assign unused_hdr_len = ^rx_hdr_length_i;

  assign rx_hdr_hs = rx_hdr_valid_i && hdr_rdy_q;
  assign rx_beat   = rx_tvalid_i && rx_tready_o;
  assign tx_hdr_hs = hdr_vld_q && tx_hdr_ready_i;
  assign tx_beat   = tx_vld_q && tx_tready_i;
  assign wr_full   = (wr_ptr_q == DEPTH16);
  assign wr_en     = (state_q == S_RX) && rx_beat && !wr_full;
  assign frame_ok  = !rx_tuser_i && !ovf_q && !wr_full;
  assign hdr_load  = (state_q == S_RX) && rx_beat && rx_tlast_i && frame_ok;

  // Two-stage read path: RAM register then output register, each advancing only when downstream has room.
  assign out_adv  = !tx_vld_q || tx_tready_i;
  assign rd_issue = (state_q == S_TX_DATA) && (rd_ptr_q < len_q) && (!rd_vld_q || out_adv);

  always_comb begin
    state_d     = state_q;
    src_ip_d    = src_ip_q;
    src_port_d  = src_port_q;
    inv_d       = inv_q;
    cnt_drain_d = cnt_drain_q;
    wr_ptr_d    = wr_ptr_q;
    ovf_d       = ovf_q;
    len_d       = len_q;
    rd_ptr_d    = rd_ptr_q;
    hdr_vld_d   = hdr_vld_q;
    stat_rx_d   = stat_rx_q;
    stat_tx_d   = stat_tx_q;
    stat_drop_d = stat_drop_q;
    case (state_q)
      S_IDLE: begin
        if (rx_hdr_hs) begin
          src_ip_d    = rx_hdr_source_ip_i;
          src_port_d  = rx_hdr_source_port_i;
          inv_d       = (cfg_mode == 2'd1);
          cnt_drain_d = (rx_hdr_dest_port_i == PORT16);
          wr_ptr_d    = 16'd0;
          ovf_d       = 1'b0;
          if ((rx_hdr_dest_port_i == PORT16) && !cfg_mode[1]) begin
            state_d = S_RX;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_RX: begin
        if (rx_beat) begin
          if (wr_full) begin
            ovf_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 16'd1;
          end
          if (rx_tlast_i) begin
            if (frame_ok) begin
              stat_rx_d = stat_rx_q + 16'd1;
              len_d     = wr_ptr_q + 16'd1;
              hdr_vld_d = 1'b1;
              state_d   = S_TX_HDR;
            end else begin
              stat_drop_d = stat_drop_q + 16'd1;
              state_d     = S_IDLE;
            end
          end
        end
      end
      S_DRAIN: begin
        if (rx_beat && rx_tlast_i) begin
          if (cnt_drain_q) begin
            stat_drop_d = stat_drop_q + 16'd1;
          end
          state_d = S_IDLE;
        end
      end
      S_TX_HDR: begin
        if (tx_hdr_hs) begin
          hdr_vld_d = 1'b0;
          rd_ptr_d  = 16'd0;
          state_d   = S_TX_DATA;
        end
      end
      S_TX_DATA: begin
        if (rd_issue) begin
          rd_ptr_d = rd_ptr_q + 16'd1;
        end
        if (tx_beat && tx_last_q) begin
          stat_tx_d = stat_tx_q + 16'd1;
          rd_ptr_d  = 16'd0;
          wr_ptr_d  = 16'd0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hdr_rdy_q   <= 1'b0;
      src_ip_q    <= 32'd0;
      src_port_q  <= 16'd0;
      inv_q       <= 1'b0;
      cnt_drain_q <= 1'b0;
      wr_ptr_q    <= 16'd0;
      ovf_q       <= 1'b0;
      len_q       <= 16'd0;
      rd_ptr_q    <= 16'd0;
      hdr_vld_q   <= 1'b0;
      stat_rx_q   <= 16'd0;
      stat_tx_q   <= 16'd0;
      stat_drop_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      hdr_rdy_q   <= (state_d == S_IDLE);
      src_ip_q    <= src_ip_d;
      src_port_q  <= src_port_d;
      inv_q       <= inv_d;
      cnt_drain_q <= cnt_drain_d;
      wr_ptr_q    <= wr_ptr_d;
      ovf_q       <= ovf_d;
      len_q       <= len_d;
      rd_ptr_q    <= rd_ptr_d;
      hdr_vld_q   <= hdr_vld_d;
      stat_rx_q   <= stat_rx_d;
      stat_tx_q   <= stat_tx_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_ttl_q      <= 8'd0;
      hdr_src_ip_q   <= 32'd0;
      hdr_dst_ip_q   <= 32'd0;
      hdr_src_port_q <= 16'd0;
      hdr_dst_port_q <= 16'd0;
      hdr_len_q      <= 16'd0;
    end else if (hdr_load) begin
      hdr_ttl_q      <= TTL8;
      hdr_src_ip_q   <= local_ip;
      hdr_dst_ip_q   <= src_ip_q;
      hdr_src_port_q <= PORT16;
      hdr_dst_port_q <= src_port_q;
      hdr_len_q      <= wr_ptr_q + 16'd9;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      tx_vld_q  <= 1'b0;
      tx_dat_q  <= 8'd0;
      tx_last_q <= 1'b0;
    end else begin
      if (rd_issue) begin
        rd_vld_q  <= 1'b1;
        rd_last_q <= (rd_ptr_q == len_q - 16'd1);
      end else if (out_adv) begin
        rd_vld_q  <= 1'b0;
      end
      if (out_adv) begin
        tx_vld_q <= rd_vld_q;
        if (rd_vld_q) begin
          tx_dat_q  <= inv_q ? ~rd_dat_q : rd_dat_q;
          tx_last_q <= rd_last_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= rx_tdata_i;
    end
    if (rd_issue) begin
      rd_dat_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

  assign rx_hdr_ready_o    = hdr_rdy_q;
  assign rx_tready_o       = (state_q == S_RX) || (state_q == S_DRAIN);
  assign tx_hdr_valid_o    = hdr_vld_q;
  assign tx_ip_dscp_o      = 6'd0;
  assign tx_ip_ecn_o       = 2'd0;
  assign tx_ip_ttl_o       = hdr_ttl_q;
  assign tx_ip_source_ip_o = hdr_src_ip_q;
  assign tx_ip_dest_ip_o   = hdr_dst_ip_q;
  assign tx_source_port_o  = hdr_src_port_q;
  assign tx_dest_port_o    = hdr_dst_port_q;
  assign tx_length_o       = hdr_len_q;
  assign tx_checksum_o     = 16'd0;
  assign tx_tdata_o        = tx_dat_q;
  assign tx_tvalid_o       = tx_vld_q;
  assign tx_tlast_o        = tx_last_q;
  assign tx_tuser_o        = 1'b0;
  assign stat_rx_frames    = stat_rx_q;
  assign stat_tx_frames    = stat_tx_q;
  assign stat_drop_frames  = stat_drop_q;
  assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_udp_loopback_buffered.sv
// Directed bench for udp_loopback_buffered (DEPTH=128): payload scoreboard queue filled on send, drained on reply.
module tb_udp_loopback_buffered;
  localparam int DEPTH = 128;
  localparam logic [31:0] LOCAL_IP = 32'hC0A80001;
  localparam logic [31:0] PEER_IP  = 32'h0A000002;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cfg_mode;
  logic        rx_hdr_valid_i, rx_hdr_ready_o;
  logic [31:0] rx_hdr_source_ip_i;
  logic [15:0] rx_hdr_source_port_i, rx_hdr_dest_port_i, rx_hdr_length_i;
  logic [7:0]  rx_tdata_i;
  logic        rx_tvalid_i, rx_tready_o, rx_tlast_i, rx_tuser_i;
  logic        tx_hdr_valid_o, tx_hdr_ready_i;
  logic [5:0]  tx_ip_dscp_o;
  logic [1:0]  tx_ip_ecn_o;
  logic [7:0]  tx_ip_ttl_o;
  logic [31:0] tx_ip_source_ip_o, tx_ip_dest_ip_o;
  logic [15:0] tx_source_port_o, tx_dest_port_o, tx_length_o, tx_checksum_o;
  logic [7:0]  tx_tdata_o;
  logic        tx_tvalid_o, tx_tready_i, tx_tlast_o, tx_tuser_o;
  logic [15:0] stat_rx_frames, stat_tx_frames, stat_drop_frames;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int e_rx = 0, e_tx = 0, e_drop = 0;
  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];

  udp_loopback_buffered #(.UDP_PORT(1234), .DEPTH(DEPTH), .TTL(64)) dut (
    .clk(clk), .reset(reset), .local_ip(LOCAL_IP), .cfg_mode(cfg_mode),
    .rx_hdr_valid_i(rx_hdr_valid_i), .rx_hdr_ready_o(rx_hdr_ready_o),
    .rx_hdr_source_ip_i(rx_hdr_source_ip_i), .rx_hdr_source_port_i(rx_hdr_source_port_i),
    .rx_hdr_dest_port_i(rx_hdr_dest_port_i), .rx_hdr_length_i(rx_hdr_length_i),
    .rx_tdata_i(rx_tdata_i), .rx_tvalid_i(rx_tvalid_i), .rx_tready_o(rx_tready_o),
    .rx_tlast_i(rx_tlast_i), .rx_tuser_i(rx_tuser_i),
    .tx_hdr_valid_o(tx_hdr_valid_o), .tx_hdr_ready_i(tx_hdr_ready_i),
    .tx_ip_dscp_o(tx_ip_dscp_o), .tx_ip_ecn_o(tx_ip_ecn_o), .tx_ip_ttl_o(tx_ip_ttl_o),
    .tx_ip_source_ip_o(tx_ip_source_ip_o), .tx_ip_dest_ip_o(tx_ip_dest_ip_o),
    .tx_source_port_o(tx_source_port_o), .tx_dest_port_o(tx_dest_port_o),
    .tx_length_o(tx_length_o), .tx_checksum_o(tx_checksum_o),
    .tx_tdata_o(tx_tdata_o), .tx_tvalid_o(tx_tvalid_o), .tx_tready_i(tx_tready_i),
    .tx_tlast_o(tx_tlast_o), .tx_tuser_o(tx_tuser_o),
    .stat_rx_frames(stat_rx_frames), .stat_tx_frames(stat_tx_frames),
    .stat_drop_frames(stat_drop_frames), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats();
    check("stat_rx", 64'(stat_rx_frames), 64'(e_rx));
    check("stat_tx", 64'(stat_tx_frames), 64'(e_tx));
    check("stat_drop", 64'(stat_drop_frames), 64'(e_drop));
  endtask

  task automatic send_hdr(input logic [31:0] ip, input logic [15:0] sport, input logic [15:0] dport);
    int n = 0;
    rx_hdr_source_ip_i   = ip;
    rx_hdr_source_port_i = sport;
    rx_hdr_dest_port_i   = dport;
    rx_hdr_length_i      = 16'(pay_q.size() + 8);
    rx_hdr_valid_i       = 1'b1;
    while (!rx_hdr_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("hdr_accept_timeout", 64'(n), 64'd0);
    @(negedge clk);
    rx_hdr_valid_i = 1'b0;
  endtask

  task automatic send_payload(input bit tuser_last, input bit expect_reply, input bit inv);
    int n;
    for (int i = 0; i < pay_q.size(); i++) begin
      rx_tdata_i  = pay_q[i];
      rx_tvalid_i = 1'b1;
      rx_tlast_i  = (i == pay_q.size() - 1);
      rx_tuser_i  = rx_tlast_i && tuser_last;
      n = 0;
      while (!rx_tready_o && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        check("rx_beat_timeout", 64'(n), 64'd0);
        break;
      end
      @(negedge clk);
      if (expect_reply) exp_q.push_back(inv ? ~pay_q[i] : pay_q[i]);
    end
    rx_tvalid_i = 1'b0;
    rx_tlast_i  = 1'b0;
    rx_tuser_i  = 1'b0;
  endtask

  task automatic recv_reply(input logic [15:0] dport, input logic [15:0] len, input bit bp, input int stop_after);
    int n = 0, beats = 0, first_n = -1, last_n = 0;
    bit done = 0, rx_seen = 0;
    logic [7:0] e;
    tx_hdr_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!(tx_hdr_valid_o && tx_hdr_ready_i) && n < 500) begin
      @(negedge clk);
      n++;
      tx_hdr_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (n >= 500) begin
      check("tx_hdr_timeout", 64'(n), 64'd0);
      tx_hdr_ready_i = 1'b0;
      return;
    end
    check("hdr_dest_ip", 64'(tx_ip_dest_ip_o), 64'(PEER_IP));
    check("hdr_src_ip", 64'(tx_ip_source_ip_o), 64'(LOCAL_IP));
    check("hdr_src_port", 64'(tx_source_port_o), 64'd1234);
    check("hdr_dest_port", 64'(tx_dest_port_o), 64'(dport));
    check("hdr_length", 64'(tx_length_o), 64'(len));
    check("hdr_ttl", 64'(tx_ip_ttl_o), 64'd64);
    check("hdr_zero_fields", {48'd0, tx_checksum_o ^ {8'd0, tx_ip_dscp_o, tx_ip_ecn_o}}, 64'd0);
    @(negedge clk);
    tx_hdr_ready_i = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      tx_tready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rx_tready_o) rx_seen = 1;
      if (tx_tvalid_o && tx_tready_i) begin
        if (first_n < 0) first_n = n;
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 64'(tx_tdata_o), 64'hFFFF);
          done = 1;
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 64'(tx_tdata_o), 64'(e));
          check("beat_last", 64'(tx_tlast_o), 64'(exp_q.size() == 0));
          check("beat_tuser", 64'(tx_tuser_o), 64'd0);
          beats++;
          last_n = n;
          if (tx_tlast_o || (stop_after > 0 && beats == stop_after)) done = 1;
        end
      end
      @(negedge clk);
      n++;
    end
    tx_tready_i = 1'b0;
    if (stop_after == 0) begin
      check("reply_done", 64'(done), 64'd1);
      check("sb_empty", 64'(exp_q.size()), 64'd0);
      check("rx_ready_low_during_tx", 64'(rx_seen), 64'd0);
      check("idle_after_reply", 64'(busy), 64'd0);
      if (!bp) begin
        check("first_beat_latency_ok", 64'(first_n >= 0 && first_n <= 2), 64'd1);
        check("throughput", 64'(last_n - first_n), 64'(len - 16'd9));
      end
    end
  endtask

  task automatic no_reply(input int cycles);
    bit seen = 0;
    repeat (cycles) begin
      if (tx_hdr_valid_o || tx_tvalid_o) seen = 1;
      @(negedge clk);
    end
    check("no_reply", 64'(seen), 64'd0);
    check("idle_after_drop", 64'(busy), 64'd0);
  endtask

  task automatic fill(input int len, input int seed);
    pay_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back(8'(i * 3 + seed));
  endtask

  initial begin
    reset = 1'b1; cfg_mode = 2'd0;
    rx_hdr_valid_i = 0; rx_hdr_source_ip_i = 0; rx_hdr_source_port_i = 0;
    rx_hdr_dest_port_i = 0; rx_hdr_length_i = 0;
    rx_tdata_i = 0; rx_tvalid_i = 0; rx_tlast_i = 0; rx_tuser_i = 0;
    tx_hdr_ready_i = 0; tx_tready_i = 0;
    repeat (2) @(negedge clk);
    check("rst_hdr_ready", 64'(rx_hdr_ready_o), 64'd0);
    check("rst_rx_tready", 64'(rx_tready_o), 64'd0);
    check("rst_tx_hdr_valid", 64'(tx_hdr_valid_o), 64'd0);
    check("rst_tx_tvalid", 64'(tx_tvalid_o), 64'd0);
    check("rst_hdr_fields", {tx_ip_dest_ip_o, tx_length_o, tx_ip_ttl_o, 8'd0}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check_stats();
    reset = 1'b0;
    #1 check("hdr_ready_before_clk", 64'(rx_hdr_ready_o), 64'd0);
    @(negedge clk);
    check("hdr_ready_after_clk", 64'(rx_hdr_ready_o), 64'd1);

    // Plain echo with header-latency check
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_hdr(PEER_IP, 16'd5000, 16'd1234);
    send_payload(0, 1, 0);
    check("tx_hdr_latency", 64'(tx_hdr_valid_o), 64'd1);
    recv_reply(16'd5000, 16'd12, 0, 0);
    e_rx++; e_tx++;
    check_stats();

    // Invert echo; mode change after acceptance must not affect this frame
    cfg_mode = 2'd1;
    pay_q = '{8'h00, 8'hA5, 8'hFF};
    send_hdr(PEER_IP, 16'd6000, 16'd1234);
    cfg_mode = 2'd0;
    send_payload(0, 1, 1);
    recv_reply(16'd6000, 16'd11, 0, 0);
    e_rx++; e_tx++;
    check_stats();

    // Exactly DEPTH bytes echoed
    fill(DEPTH, 7);
    send_hdr(PEER_IP, 16'd5001, 16'd1234);
    send_payload(0, 1, 0);
    recv_reply(16'd5001, 16'(DEPTH + 8), 0, 0);
    e_rx++; e_tx++;
    check_stats();

    // DEPTH+1 bytes dropped
    fill(DEPTH + 1, 9);
    send_hdr(PEER_IP, 16'd5002, 16'd1234);
    send_payload(0, 0, 0);
    no_reply(20);
    e_drop++;
    check_stats();

    // Foreign port drained silently
    fill(5, 1);
    send_hdr(PEER_IP, 16'd5003, 16'd80);
    send_payload(0, 0, 0);
    no_reply(20);
    check_stats();

    // Errored frame dropped and counted
    fill(6, 2);
    send_hdr(PEER_IP, 16'd5004, 16'd1234);
    send_payload(1, 0, 0);
    no_reply(20);
    e_drop++;
    check_stats();

    // Disabled mode drops and counts
    cfg_mode = 2'd2;
    fill(4, 3);
    send_hdr(PEER_IP, 16'd5005, 16'd1234);
    send_payload(0, 0, 0);
    no_reply(20);
    e_drop++;
    check_stats();
    cfg_mode = 2'd0;

    // Random backpressure on both tx channels
    fill(100, 11);
    send_hdr(PEER_IP, 16'd7000, 16'd1234);
    send_payload(0, 1, 0);
    recv_reply(16'd7000, 16'd108, 1, 0);
    e_rx++; e_tx++;
    check_stats();

    // Reset in the middle of a reply
    fill(50, 5);
    send_hdr(PEER_IP, 16'd7001, 16'd1234);
    send_payload(0, 1, 0);
    recv_reply(16'd7001, 16'd58, 0, 5);
    #2 reset = 1'b1;
    #1;
    check("midrst_tvalid", 64'(tx_tvalid_o), 64'd0);
    check("midrst_hdr_valid", 64'(tx_hdr_valid_o), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hdr_ready", 64'(rx_hdr_ready_o), 64'd0);
    e_rx = 0; e_tx = 0; e_drop = 0;
    check_stats();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pay_q = '{8'h3C, 8'h00, 8'hC3};
    send_hdr(PEER_IP, 16'd7002, 16'd1234);
    send_payload(0, 1, 0);
    recv_reply(16'd7002, 16'd11, 0, 0);
    e_rx++; e_tx++;
    check_stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
